imem_fetch_ctrl: RTL and testbench

//  Instruction-fetch side of the PC path. Takes the current PC from the PC register
//  and issues it as a read request to instruction memory over a valid/ready interface.

---
 rtl/rv_fetch_pkg.sv | 24 ++
 rtl/imem_fetch_ctrl_if.sv | 32 +++
 rtl/fetch_queue.sv | 55 +++++
 rtl/imem_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction-fetch path: FSM states, entry layout, helpers.
package rv_fetch_pkg;

  localparam int XLEN = 32;

  // IDLE: waiting for credit; REQ: request on the bus; WAIT: response expected;
  // DROP: response expected but it belongs to a flushed fetch.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and memory (slave).
//
// Handshake: a request transfers on a rising edge where imem_req_valid_out and
// imem_req_ready_in are both 1. Once valid is raised, valid and addr stay
// unchanged until that edge. Memory returns exactly one imem_rsp_valid_in pulse
// (with imem_rsp_data_in) per transferred request, no earlier than the cycle
// after the transfer; there is no back-pressure on responses.
interface imem_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid_out;
  logic [XLEN-1:0] imem_req_addr_out;
  logic            imem_req_ready_in;
  logic            imem_rsp_valid_in;
  logic [XLEN-1:0] imem_rsp_data_in;

  modport master (
    output imem_req_valid_out,
    output imem_req_addr_out,
    input  imem_req_ready_in,
    input  imem_rsp_valid_in,
    input  imem_rsp_data_in
  );

  modport slave (
    input  imem_req_valid_out,
    input  imem_req_addr_out,
    output imem_req_ready_in,
    output imem_rsp_valid_in,
    output imem_rsp_data_in
  );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc,instr} entries; head is always visible.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          mp_clk_in,
  input  logic          mp_rst_in,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Pointer and occupancy tracking; flush empties the queue in one edge.
  always_ff @(posedge mp_clk_in or posedge mp_rst_in) begin
    if (mp_rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset.
  always_ff @(posedge mp_clk_in) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Upstream credit accounting must never push into a full queue without a pop.
  always_ff @(posedge mp_clk_in) begin
    if (!mp_rst_in && !flush) assert (!(push && full && !pop));
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: issues pc_in to instruction memory, queues returned words for decode.
module imem_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              Q_DEPTH   = 2,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
  input  logic               mp_clk_in,
  input  logic               mp_rst_in,
  input  logic [XLEN-1:0]    pc_in,
  input  logic               flush_in,
  output logic               pc_adv_out,
  imem_fetch_ctrl_if.master  imem,
  output logic               instr_valid_out,
  output logic [XLEN-1:0]    instr_out,
  output logic [XLEN-1:0]    instr_pc_out,
  input  logic               instr_ready_in,
  output logic               misalign_err_out,
  output fetch_state_e       state_dbg_out
);
  localparam int CW = $clog2(Q_DEPTH + 1);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            flush_pend_q, flush_pend_d;
  logic            err_q, err_d;
  logic            push;
  logic            pop;
  logic            outstanding;
  logic            credit_ok;
  logic            flushing;
  logic [CW-1:0]   q_count;
  logic            q_full;
  logic            q_empty;
  logic [2*XLEN-1:0] q_head;

  // A new fetch may start only if its response is guaranteed a queue slot.
  assign outstanding = (state_q != ST_IDLE);
  assign credit_ok   = ({1'b0, q_count} + {{CW{1'b0}}, outstanding}) < (CW+1)'(Q_DEPTH);
  assign flushing    = flush_in | flush_pend_q;

  // State, latched fetch address, pending-flush and sticky error registers.
  always_ff @(posedge mp_clk_in or posedge mp_rst_in) begin
    if (mp_rst_in) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      err_q        <= err_d;
    end
  end

  // Next-state and bus/pulse outputs for the single-outstanding fetch FSM.
  always_comb begin
    state_d                 = state_q;
    addr_d                  = addr_q;
    flush_pend_d            = flush_pend_q;
    err_d                   = flush_in ? 1'b0 : err_q;
    imem.imem_req_valid_out = 1'b0;
    pc_adv_out              = 1'b0;
    push                    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush_in && credit_ok) begin
          if (word_aligned(pc_in[1:0])) begin
            addr_d  = pc_in;
            state_d = ST_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        imem.imem_req_valid_out = 1'b1;
        if (imem.imem_req_ready_in) begin
          pc_adv_out   = !flushing;
          state_d      = flushing ? ST_DROP : ST_WAIT;
          flush_pend_d = 1'b0;
        end else if (flush_in) begin
          flush_pend_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem.imem_rsp_valid_in) begin
          push    = !flush_in;
          state_d = ST_IDLE;
        end else if (flush_in) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem.imem_rsp_valid_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req_addr_out = addr_q;
  assign misalign_err_out       = err_q;
  assign state_dbg_out          = state_q;

  assign pop = instr_valid_out & instr_ready_in;

  fetch_queue #(
    .W     (2*XLEN),
    .DEPTH (Q_DEPTH),
    .CW    (CW)
  ) u_queue (
    .mp_clk_in (mp_clk_in),
    .mp_rst_in (mp_rst_in),
    .push      (push),
    .push_data ({addr_q, imem.imem_rsp_data_in}),
    .pop       (pop),
    .flush     (flush_in),
    .head_data (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign instr_valid_out = !q_empty;
  assign instr_out       = q_empty ? '0 : q_head[XLEN-1:0];
  assign instr_pc_out    = q_empty ? BOOT_ADDR : q_head[2*XLEN-1:XLEN];

  // Responses with no fetch outstanding are ignored but must never happen.
  always_ff @(posedge mp_clk_in) begin
    if (!mp_rst_in) begin
      assert (!(imem.imem_rsp_valid_in && (state_q == ST_IDLE || state_q == ST_REQ)));
      assert (!(q_full && push && !pop));
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized run against a memory/PC model.
module tb_imem_fetch_ctrl;
  import rv_fetch_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        pc_adv;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        err;
  fetch_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  imem_fetch_ctrl_if #(.XLEN(32)) bus ();

  imem_fetch_ctrl #(.XLEN(32), .Q_DEPTH(2), .BOOT_ADDR(BOOT)) dut (
    .mp_clk_in        (clk),
    .mp_rst_in        (rst),
    .pc_in            (pc_in),
    .flush_in         (flush),
    .pc_adv_out       (pc_adv),
    .imem             (bus),
    .instr_valid_out  (instr_valid),
    .instr_out        (instr),
    .instr_pc_out     (instr_pc),
    .instr_ready_in   (instr_ready),
    .misalign_err_out (err),
    .state_dbg_out    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pc_in = '0; flush = 1'b0; instr_ready = 1'b0;
    bus.imem_req_ready_in = 1'b0; bus.imem_rsp_valid_in = 1'b0; bus.imem_rsp_data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, bus.imem_req_valid_out, 1'b0);
    check({tag, "_req_addr"}, bus.imem_req_addr_out, 32'h0);
    check({tag, "_pc_adv"}, pc_adv, 1'b0);
    check({tag, "_instr_valid"}, instr_valid, 1'b0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_instr_pc"}, instr_pc, BOOT);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // random-phase memory model state
  logic [31:0] pc_model;
  logic        rsp_pending;
  int          rsp_wait;
  logic [31:0] rsp_addr;
  logic        rsp_prev;
  logic [63:0] e;

  initial begin
    // ---- reset mid-WAIT ----
    do_reset();
    check_reset_values("rst_init");
    pc_in = 32'h0; bus.imem_req_ready_in = 1'b1;
    tick();                                   // IDLE -> REQ
    settle(); check("t1_adv", pc_adv, 1'b1);
    tick();                                   // REQ -> WAIT
    bus.imem_req_ready_in = 1'b0;
    settle(); check("t1_wait", 32'(state_dbg), 32'(ST_WAIT));
    rst = 1'b1; #1;
    check_reset_values("rst_mid");
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h1111_1111;
    tick();
    bus.imem_rsp_valid_in = 1'b0; rst = 1'b0;
    settle(); tick(); tick(); settle();
    check("t1_no_push", instr_valid, 1'b0);

    // ---- single fetch ----
    do_reset();
    pc_in = 32'h0; bus.imem_req_ready_in = 1'b1;
    tick();
    settle();
    check("t2_req_valid", bus.imem_req_valid_out, 1'b1);
    check("t2_addr", bus.imem_req_addr_out, 32'h0);
    check("t2_adv", pc_adv, 1'b1);
    tick();                                   // WAIT
    bus.imem_req_ready_in = 1'b0; pc_in = 32'h4;
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h0050_0093;
    settle(); check("t2_adv_pulse", pc_adv, 1'b0);
    tick();                                   // push -> IDLE
    bus.imem_rsp_valid_in = 1'b0;
    settle();
    check("t2_valid", instr_valid, 1'b1);
    check("t2_instr", instr, 32'h0050_0093);
    check("t2_pc", instr_pc, 32'h0);

    // ---- queue fills, no third request until pop ----
    tick();                                   // REQ for 0x4
    bus.imem_req_ready_in = 1'b1;
    settle();
    check("t3_addr4", bus.imem_req_addr_out, 32'h4);
    check("t3_adv4", pc_adv, 1'b1);
    tick();                                   // WAIT
    bus.imem_req_ready_in = 1'b0; pc_in = 32'h8;
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h00A0_0113;
    tick();                                   // push, count = 2
    bus.imem_rsp_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_no_req", bus.imem_req_valid_out, 1'b0);
      check("t3_head", instr, 32'h0050_0093);
      tick();
    end
    instr_ready = 1'b1;
    tick();                                   // pop
    instr_ready = 1'b0;
    settle();
    check("t3_head2", instr, 32'h00A0_0113);
    check("t3_head2_pc", instr_pc, 32'h4);
    check("t3_still_no_req", bus.imem_req_valid_out, 1'b0);
    tick();
    settle();
    check("t3_req8", bus.imem_req_valid_out, 1'b1);
    check("t3_addr8", bus.imem_req_addr_out, 32'h8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check("t3_flush_clears", instr_valid, 1'b0);
    check("t3_flush_pc", instr_pc, BOOT);

    // ---- flush in WAIT, then DROP ----
    do_reset();
    pc_in = 32'h10; bus.imem_req_ready_in = 1'b1; instr_ready = 1'b1;
    tick();
    settle(); check("t4_adv", pc_adv, 1'b1);
    tick();                                   // WAIT
    bus.imem_req_ready_in = 1'b0; flush = 1'b1;
    tick();                                   // DROP
    flush = 1'b0;
    settle(); check("t4_drop", 32'(state_dbg), 32'(ST_DROP));
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hDEAD_BEEF; pc_in = 32'h20;
    tick();
    bus.imem_rsp_valid_in = 1'b0;
    settle();
    check("t4_dropped", instr_valid, 1'b0);
    check("t4_idle", 32'(state_dbg), 32'(ST_IDLE));
    tick();
    settle();
    check("t4_req", bus.imem_req_valid_out, 1'b1);
    check("t4_new_addr", bus.imem_req_addr_out, 32'h20);
    // flush coincident with response goes straight to IDLE
    bus.imem_req_ready_in = 1'b1;
    tick();                                   // WAIT
    bus.imem_req_ready_in = 1'b0; flush = 1'b1;
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'hCAFE_F00D;
    tick();
    flush = 1'b0; bus.imem_rsp_valid_in = 1'b0;
    settle();
    check("t4_coinc_idle", 32'(state_dbg), 32'(ST_IDLE));
    check("t4_coinc_empty", instr_valid, 1'b0);
    // flush while request is on the bus suppresses pc_adv
    pc_in = 32'h30;
    tick();                                   // REQ
    flush = 1'b1; bus.imem_req_ready_in = 1'b1;
    settle();
    check("t4_flush_req_valid", bus.imem_req_valid_out, 1'b1);
    check("t4_flush_adv", pc_adv, 1'b0);
    tick();
    flush = 1'b0; bus.imem_req_ready_in = 1'b0;
    settle(); check("t4_flush_drop", 32'(state_dbg), 32'(ST_DROP));
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h1234_5678;
    tick();
    bus.imem_rsp_valid_in = 1'b0;
    settle(); check("t4_flush_empty", instr_valid, 1'b0);
    // flush pending across a stalled request
    tick();                                   // REQ
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.imem_req_ready_in = 1'b1;
    settle(); check("t4_pend_adv", pc_adv, 1'b0);
    tick();
    bus.imem_req_ready_in = 1'b0;
    settle(); check("t4_pend_drop", 32'(state_dbg), 32'(ST_DROP));
    bus.imem_rsp_valid_in = 1'b1;
    tick();
    bus.imem_rsp_valid_in = 1'b0;

    // ---- memory stall: request held stable ----
    do_reset();
    pc_in = 32'h40;
    tick();                                   // REQ
    pc_in = 32'h44;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("t5_valid", bus.imem_req_valid_out, 1'b1);
      check("t5_addr", bus.imem_req_addr_out, 32'h40);
      check("t5_no_adv", pc_adv, 1'b0);
      tick();
    end
    bus.imem_req_ready_in = 1'b1;
    settle();
    check("t5_adv", pc_adv, 1'b1);
    check("t5_addr_acc", bus.imem_req_addr_out, 32'h40);
    tick();
    bus.imem_req_ready_in = 1'b0;
    settle();
    check("t5_adv_after", pc_adv, 1'b0);
    check("t5_valid_after", bus.imem_req_valid_out, 1'b0);
    bus.imem_rsp_valid_in = 1'b1; bus.imem_rsp_data_in = 32'h0000_0013;
    tick();
    bus.imem_rsp_valid_in = 1'b0;
    settle(); check("t5_pc", instr_pc, 32'h40);

    // ---- misaligned PC ----
    do_reset();
    pc_in = 32'h2;
    tick(); settle();
    check("t6_err", err, 1'b1);
    check("t6_no_req", bus.imem_req_valid_out, 1'b0);
    repeat (3) tick();
    settle();
    check("t6_err_sticky", err, 1'b1);
    check("t6_idle", 32'(state_dbg), 32'(ST_IDLE));
    flush = 1'b1; pc_in = 32'h0;
    tick();
    flush = 1'b0;
    settle(); check("t6_err_cleared", err, 1'b0);
    tick(); settle();
    check("t6_req_after", bus.imem_req_valid_out, 1'b1);
    check("t6_addr_after", bus.imem_req_addr_out, 32'h0);

    // ---- randomized run against memory / PC-register model ----
    do_reset();
    pc_model    = 32'($urandom_range(0, 255)) << 2;
    rsp_pending = 1'b0; rsp_wait = 0; rsp_addr = '0; rsp_prev = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.imem_req_ready_in = ($urandom_range(0, 3) != 0);
      instr_ready           = ($urandom_range(0, 2) != 0);
      pc_in                 = pc_model;
      if (rsp_pending && rsp_wait == 0) begin
        bus.imem_rsp_valid_in = 1'b1;
        bus.imem_rsp_data_in  = mem_word(rsp_addr);
        rsp_pending           = 1'b0;
      end else begin
        bus.imem_rsp_valid_in = 1'b0;
        bus.imem_rsp_data_in  = $urandom;
        if (rsp_pending) rsp_wait--;
      end
      settle();
      if (rsp_prev) check("rnd_rsp_latency", instr_valid, 1'b1);
      rsp_prev = bus.imem_rsp_valid_in;
      check("rnd_pc_adv", pc_adv, bus.imem_req_valid_out & bus.imem_req_ready_in);
      if (bus.imem_req_valid_out) check("rnd_req_addr", bus.imem_req_addr_out, pc_model);
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_instr", instr_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rnd_instr_pc", instr_pc, e[63:32]);
          check("rnd_instr", instr, e[31:0]);
        end
      end
      if (bus.imem_req_valid_out && bus.imem_req_ready_in) begin
        exp_q.push_back({bus.imem_req_addr_out, mem_word(bus.imem_req_addr_out)});
        check("rnd_credit", exp_q.size() <= 2, 1'b1);
        rsp_pending = 1'b1;
        rsp_wait    = $urandom_range(0, 2);
        rsp_addr    = bus.imem_req_addr_out;
        pc_model    = pc_model + 32'h4;
      end
      tick();
    end
    rst = 1'b1;

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends with a report.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit reached");
  end
endmodule
